// File: rtl/tiny_alu_pkg.sv
// rtl/tiny_alu_pkg.sv - shared opcode and state types for tiny_alu_mc
package tiny_alu_pkg;

  localparam int OP_BITS = 3;

  typedef enum logic [OP_BITS-1:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MUL = 3'd4,
    OP_SUB = 3'd5,
    OP_OR  = 3'd6
  } op_e;

  typedef enum logic {
    IDLE,
    MUL_RUN
  } state_e;

endpackage

// File: rtl/tiny_alu_mc_if.sv
// rtl/tiny_alu_mc_if.sv - start/busy/done request and result bundle for tiny_alu_mc
interface tiny_alu_mc_if
  import tiny_alu_pkg::*;
#(
  parameter int DATA_BITS = 8
) ();

  logic                   start_i;
  logic [OP_BITS-1:0]     opcode_i;
  logic [DATA_BITS-1:0]   a_i;
  logic [DATA_BITS-1:0]   b_i;
  logic                   busy_o;
  logic                   done_o;
  logic [2*DATA_BITS-1:0] result_o;
  logic                   error_o;

  modport master (
    output start_i, opcode_i, a_i, b_i,
    input  busy_o, done_o, result_o, error_o
  );

  modport slave (
    input  start_i, opcode_i, a_i, b_i,
    output busy_o, done_o, result_o, error_o
  );

endinterface

// File: rtl/tiny_alu_mc_mul.sv
// rtl/tiny_alu_mc_mul.sv - iterative shift-add multiplier, one partial product per cycle
// done_o/product_o are combinational and flag the cycle whose edge completes the product.
module tiny_alu_mc_mul
  import tiny_alu_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [DATA_BITS-1:0]   a_i,
  input  logic [DATA_BITS-1:0]   b_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [2*DATA_BITS-1:0] product_o
);

  localparam int RW       = 2 * DATA_BITS;
  localparam int CNT_BITS = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DATA_BITS - 1);

  state_e               state_q;
  logic [CNT_BITS-1:0]  cnt_q;
  logic [RW-1:0]        mcand_q;
  logic [DATA_BITS-1:0] mplier_q;
  logic [RW-1:0]        acc_q;

  logic [RW-1:0] partial;
  logic [RW-1:0] sum;
  logic          last;

  assign partial = mplier_q[0] ? mcand_q : '0;
  assign sum     = acc_q + partial;
  assign last    = (state_q == MUL_RUN) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mcand_q  <= RW'(a_i);
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          acc_q    <= sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (last) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_BITS'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q == MUL_RUN);
  assign done_o    = last;
  assign product_o = sum;

endmodule

// File: rtl/tiny_alu_mc.sv
// rtl/tiny_alu_mc.sv - multi-cycle tiny ALU: opcode decode, output registers, handshake
// Build option TINY_ALU_MC_FAST_MUL_EN: single-cycle combinational multiply, no busy phase.
module tiny_alu_mc
  import tiny_alu_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input logic         clk_i,
  input logic         reset_i,
  tiny_alu_mc_if.slave bus
);

  localparam int RW = 2 * DATA_BITS;

  logic          mul_busy;
  logic          mul_done;
  logic [RW-1:0] mul_product;
  logic          accept;

  logic [RW-1:0] result_q;
  logic          error_q;
  logic          done_q;

  logic [RW-1:0]      result_d;
  logic               error_d;
  logic               single_d;
  logic [DATA_BITS:0] add_w;
  logic [DATA_BITS:0] sub_w;

  assign accept = bus.start_i && !mul_busy;
  assign add_w  = {1'b0, bus.a_i} + {1'b0, bus.b_i};
  assign sub_w  = {1'b0, bus.a_i} - {1'b0, bus.b_i};

`ifdef TINY_ALU_MC_FAST_MUL_EN
  assign mul_busy    = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`else
  tiny_alu_mc_mul #(
    .DATA_BITS (DATA_BITS)
  ) u_mul (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (accept && (bus.opcode_i == OP_MUL)),
    .a_i       (bus.a_i),
    .b_i       (bus.b_i),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );
`endif

  // single_d low means the result arrives later from the iterative multiplier
  always_comb begin
    result_d = '0;
    error_d  = 1'b0;
    single_d = 1'b1;
    case (bus.opcode_i)
      OP_NOP: result_d = '0;
      OP_ADD: result_d = RW'(add_w);
      OP_SUB: result_d = RW'(sub_w);
      OP_AND: result_d = RW'(bus.a_i & bus.b_i);
      OP_XOR: result_d = RW'(bus.a_i ^ bus.b_i);
      OP_OR:  result_d = RW'(bus.a_i | bus.b_i);
`ifdef TINY_ALU_MC_FAST_MUL_EN
      OP_MUL: result_d = RW'(bus.a_i) * RW'(bus.b_i);
`else
      OP_MUL: single_d = 1'b0;
`endif
      default: error_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      result_q <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else if (mul_done) begin
      result_q <= mul_product;
      error_q  <= 1'b0;
      done_q   <= 1'b1;
    end else if (accept) begin
      done_q <= single_d;
      if (single_d) begin
        result_q <= result_d;
        error_q  <= error_d;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign bus.busy_o   = mul_busy;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.error_o  = error_q;

endmodule

// File: tb/tb_tiny_alu_mc.sv
// tb/tb_tiny_alu_mc.sv - directed vector bench for tiny_alu_mc at DATA_BITS 8 and 16
module tb_tiny_alu_mc;
  import tiny_alu_pkg::*;

`ifdef TINY_ALU_MC_FAST_MUL_EN
  localparam int LAT8  = 0;
  localparam int LAT16 = 0;
`else
  localparam int LAT8  = 8;
  localparam int LAT16 = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tiny_alu_mc_if #(.DATA_BITS(8))  bus8 ();
  tiny_alu_mc_if #(.DATA_BITS(16)) bus16 ();

  tiny_alu_mc #(.DATA_BITS(8))  dut8  (.clk_i(clk), .reset_i(rst), .bus(bus8));
  tiny_alu_mc #(.DATA_BITS(16)) dut16 (.clk_i(clk), .reset_i(rst), .bus(bus16));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int done_at;
    int busy_cnt;
    int done_cnt;

    vecs[0] = '{3'd1, 8'hFF, 8'h01, 16'h0100, 1'b0};
    vecs[1] = '{3'd5, 8'h05, 8'h07, 16'h01FE, 1'b0};
    vecs[2] = '{3'd3, 8'hAA, 8'h55, 16'h00FF, 1'b0};
    vecs[3] = '{3'd6, 8'h0F, 8'hF0, 16'h00FF, 1'b0};
    vecs[4] = '{3'd2, 8'hF0, 8'h3C, 16'h0030, 1'b0};
    vecs[5] = '{3'd7, 8'h12, 8'h34, 16'h0000, 1'b1};
    vecs[6] = '{3'd0, 8'h12, 8'h34, 16'h0000, 1'b0};
    vecs[7] = '{3'd1, 8'h12, 8'h34, 16'h0046, 1'b0};
    vecs[8] = '{3'd5, 8'h34, 8'h12, 16'h0022, 1'b0};

    rst = 1'b1;
    bus8.start_i = 1'b0;  bus8.opcode_i = '0;  bus8.a_i = '0;  bus8.b_i = '0;
    bus16.start_i = 1'b0; bus16.opcode_i = '0; bus16.a_i = '0; bus16.b_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_done", bus8.done_o, 0);
    chk("reset_busy", bus8.busy_o, 0);
    chk("reset_result", bus8.result_o, 0);
    chk("reset_error", bus8.error_o, 0);
    chk("reset_result16", bus16.result_o, 0);

    // back-to-back single-cycle ops, one accepted per cycle
    for (int i = 0; i < 9; i++) begin
      bus8.start_i = 1'b1;
      bus8.opcode_i = vecs[i].op;
      bus8.a_i = vecs[i].a;
      bus8.b_i = vecs[i].b;
      @(negedge clk);
      chk($sformatf("vec%0d_done", i), bus8.done_o, 1);
      chk($sformatf("vec%0d_result", i), bus8.result_o, vecs[i].res);
      chk($sformatf("vec%0d_error", i), bus8.error_o, vecs[i].err);
    end
    bus8.start_i = 1'b0;
    @(negedge clk);
    chk("idle_done", bus8.done_o, 0);
    chk("idle_result_held", bus8.result_o, 16'h0022);

    // 8-bit multiply with an ADD attempted mid-run
    bus8.start_i = 1'b1; bus8.opcode_i = OP_MUL; bus8.a_i = 8'hFF; bus8.b_i = 8'hFF;
    done_at = -1; busy_cnt = 0;
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      @(negedge clk);
      bus8.start_i = 1'b0;
      if (bus8.busy_o) busy_cnt++;
      if (bus8.done_o) done_at = i;
      if (i == 2 && LAT8 > 0) begin
        bus8.start_i = 1'b1; bus8.opcode_i = OP_ADD; bus8.a_i = 8'h01; bus8.b_i = 8'h01;
      end
    end
    chk("mul8_latency", done_at, LAT8);
    chk("mul8_busy_cycles", busy_cnt, LAT8);
    chk("mul8_result", bus8.result_o, 16'hFE01);
    chk("mul8_error", bus8.error_o, 0);
    chk("mul8_busy_after", bus8.busy_o, 0);
    @(negedge clk);
    chk("mul8_done_pulse", bus8.done_o, 0);
    chk("mul8_result_held", bus8.result_o, 16'hFE01);

    // reset during a multiply abandons it
    bus8.start_i = 1'b1; bus8.opcode_i = OP_MUL; bus8.a_i = 8'h0F; bus8.b_i = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus8.start_i = 1'b0;
      chk($sformatf("rstmul_done%0d", i), bus8.done_o, (i == LAT8) ? 1 : 0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmul_busy", bus8.busy_o, 0);
    chk("rstmul_done", bus8.done_o, 0);
    chk("rstmul_result", bus8.result_o, 0);
    chk("rstmul_error", bus8.error_o, 0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done_o) done_cnt++;
    end
    chk("rstmul_no_late_done", done_cnt, 0);
    chk("rstmul_result_quiet", bus8.result_o, 0);
    bus8.start_i = 1'b1; bus8.opcode_i = OP_AND; bus8.a_i = 8'hF0; bus8.b_i = 8'h3C;
    @(negedge clk);
    bus8.start_i = 1'b0;
    chk("post_rst_and_done", bus8.done_o, 1);
    chk("post_rst_and_result", bus8.result_o, 16'h0030);

    // 16-bit multiply
    bus16.start_i = 1'b1; bus16.opcode_i = OP_MUL; bus16.a_i = 16'hFFFF; bus16.b_i = 16'h0002;
    done_at = -1; busy_cnt = 0;
    for (int i = 0; i < 60 && done_at < 0; i++) begin
      @(negedge clk);
      bus16.start_i = 1'b0;
      if (bus16.busy_o) busy_cnt++;
      if (bus16.done_o) done_at = i;
    end
    chk("mul16_latency", done_at, LAT16);
    chk("mul16_busy_cycles", busy_cnt, LAT16);
    chk("mul16_result", bus16.result_o, 32'h0001FFFE);
    chk("mul16_error", bus16.error_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
